// File: rtl/dma_block_engine.sv
// Word-memory DMA engine: single and block reads/writes under a start/busy/done handshake.
// Block transfers move one word per cycle between the memory and a flat BLOCK_SIZE-lane bus.
module dma_block_engine #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           BLOCK_SIZE = 25,
  parameter int unsigned           MEM_DEPTH  = 2500,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 'h0400,
  parameter int unsigned           LEN_WIDTH  = $clog2(BLOCK_SIZE + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [1:0]                       mode,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [LEN_WIDTH-1:0]             length,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] block_in,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic [DATA_WIDTH*BLOCK_SIZE-1:0] block_out,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int unsigned LaneW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int unsigned MemAw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]  DepthA = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(BLOCK_SIZE);

  typedef enum logic [1:0] {StIdle, StXfer, StFinish} state_e;
  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  block_t                block_q, block_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  block_t                block_out_q, block_out_d;

  // Contents survive reset; only time zero loads INIT_VALUE.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: INIT_VALUE};

  logic [ADDR_WIDTH:0]   waddr;
  logic                  in_range;
  logic [MemAw-1:0]      mem_idx;
  logic [LaneW-1:0]      lane;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Word address is one bit wider than the port so base + k never wraps back into range.
  assign waddr    = {1'b0, addr_q} + (ADDR_WIDTH + 1)'(idx_q);
  assign in_range = waddr < DepthA;
  assign mem_idx  = waddr[MemAw-1:0];
  assign lane     = idx_q[LaneW-1:0];

  always_comb begin
    rdata = '0;
    if (in_range) begin
      rdata = mem[mem_idx];
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    data_d      = data_q;
    block_d     = block_q;
    error_d     = error_q;
    data_out_d  = data_out_q;
    block_out_d = block_out_q;
    mem_we      = 1'b0;
    mem_wdata   = (mode_q == 2'b00) ? data_q : block_q[lane];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          addr_d  = address;
          len_d   = mode[1] ? length : LEN_WIDTH'(1);
          idx_d   = '0;
          data_d  = data_in;
          block_d = block_in;
          error_d = 1'b0;
          if (mode[1] && (length == '0)) begin
            state_d = StFinish;
          end else if (mode[1] && (length > MaxLen)) begin
            state_d = StFinish;
            error_d = 1'b1;
          end else begin
            state_d = StXfer;
            // Skipped ops leave block_out alone; only a real block read clears it.
            if (mode == 2'b10) begin
              block_out_d = '0;
            end
          end
        end
      end
      StXfer: begin
        if (!in_range) begin
          error_d = 1'b1;
        end
        mem_we = in_range && ((mode_q == 2'b00) || (mode_q == 2'b11));
        if (mode_q == 2'b01) begin
          data_out_d = rdata;
        end
        if (mode_q == 2'b10) begin
          block_out_d[lane] = rdata;
        end
        if (idx_q == (len_q - LEN_WIDTH'(1))) begin
          state_d = StFinish;
        end else begin
          idx_d = idx_q + LEN_WIDTH'(1);
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      block_q     <= '0;
      error_q     <= 1'b0;
      data_out_q  <= '0;
      block_out_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      block_q     <= block_d;
      error_q     <= error_d;
      data_out_q  <= data_out_d;
      block_out_q <= block_out_d;
    end
  end

  // A write coinciding with reset belongs to the aborted op and is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  assign busy      = (state_q == StXfer);
  assign done      = (state_q == StFinish);
  assign error     = error_q;
  assign data_out  = data_out_q;
  assign block_out = block_out_q;

endmodule

// File: tb/tb_dma_block_engine.sv
// Scoreboard bench for dma_block_engine: a behavioural memory model predicts each op's
// latency, busy span, error, data_out and every block_out lane.
module tb_dma_block_engine;

  localparam int DW    = 16;
  localparam int BS    = 25;
  localparam int DEPTH = 2500;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = '0;
  logic [15:0]      address = '0;
  logic [4:0]       length = '0;
  logic [DW-1:0]    data_in = '0;
  logic [DW*BS-1:0] block_in = '0;
  logic [DW-1:0]    data_out;
  logic [DW*BS-1:0] block_out;
  logic             busy, done, error;

  dma_block_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .address   (address),
    .length    (length),
    .data_in   (data_in),
    .block_in  (block_in),
    .data_out  (data_out),
    .block_out (block_out),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          lane;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  logic [DW-1:0]    m_mem [DEPTH];
  logic [DW-1:0]    m_dout;
  logic [DW*BS-1:0] m_bo;
  logic             m_err;

  int n_cmp = 0;
  int n_bad = 0;
  int lat_obs;
  int busy_obs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int lane, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.lane = lane;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input string tag, input int lane);
    case (tag)
      "lat":   return lat_obs;
      "busy":  return busy_obs;
      "err":   return {31'd0, error};
      "dout":  return {16'd0, data_out};
      default: return {16'd0, block_out[lane*DW +: DW]};
    endcase
  endfunction

  function automatic logic [DW*BS-1:0] mk_block(input logic [DW-1:0] base);
    logic [DW*BS-1:0] b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = base + DW'(i);
    return b;
  endfunction

  // Reference behaviour of one accepted op; pushes every expectation for it.
  task automatic model_op(input logic [1:0] md, input logic [15:0] addr, input logic [4:0] len,
                          input logic [DW-1:0] din, input logic [DW*BS-1:0] blk);
    int   l;
    int   a;
    logic skip;
    m_err = 1'b0;
    skip  = 1'b0;
    if (md[1] && len == 0) skip = 1'b1;
    if (md[1] && len > BS) begin
      skip  = 1'b1;
      m_err = 1'b1;
    end
    l = md[1] ? int'(len) : 1;
    if (!skip) begin
      if (md == 2'b10) m_bo = '0;
      for (int k = 0; k < l; k++) begin
        a = int'(addr) + k;
        if (a >= DEPTH) m_err = 1'b1;
        case (md)
          2'b00: if (a < DEPTH) m_mem[a] = din;
          2'b01: m_dout = (a < DEPTH) ? m_mem[a] : '0;
          2'b10: m_bo[k*DW +: DW] = (a < DEPTH) ? m_mem[a] : '0;
          default: if (a < DEPTH) m_mem[a] = blk[k*DW +: DW];
        endcase
      end
    end
    push("lat", 0, skip ? 1 : l + 1);
    push("busy", 0, skip ? 0 : l);
    push("err", 0, {31'd0, m_err});
    push("dout", 0, {16'd0, m_dout});
    for (int i = 0; i < BS; i++) push("lane", i, {16'd0, m_bo[i*DW +: DW]});
  endtask

  task automatic launch(input logic [1:0] md, input logic [15:0] addr, input logic [4:0] len,
                        input logic [DW-1:0] din, input logic [DW*BS-1:0] blk);
    @(negedge clk);
    mode     = md;
    address  = addr;
    length   = len;
    data_in  = din;
    block_in = blk;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    // Inputs are don't-care once the op is accepted.
    mode    = 2'($urandom);
    address = 16'($urandom);
    length  = 5'($urandom);
    data_in = 16'($urandom);
    for (int i = 0; i < BS; i++) block_in[i*DW +: DW] = 16'($urandom);
  endtask

  task automatic run_op(input logic [1:0] md, input logic [15:0] addr, input logic [4:0] len,
                        input logic [DW-1:0] din, input logic [DW*BS-1:0] blk,
                        input int glitch_at);
    exp_t e;
    model_op(md, addr, len, din, blk);
    launch(md, addr, len, din, blk);
    lat_obs  = -1;
    busy_obs = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = (c == glitch_at);
      if (busy) busy_obs++;
      if (done) begin
        lat_obs = c;
        break;
      end
    end
    start = 1'b0;
    if (lat_obs < 0) check_eq("done_seen", {31'd0, done}, 32'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq((e.tag == "lane") ? $sformatf("lane%0d", e.lane) : e.tag,
               observe(e.tag, e.lane), e.exp);
    end
    @(negedge clk);
    check_eq("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0400;
    m_dout = '0;
    m_bo   = '0;
    m_err  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err", {31'd0, error}, 32'd0);
    check_eq("rst_dout", {16'd0, data_out}, 32'd0);
    check_eq("rst_bo", {31'd0, |block_out}, 32'd0);
    rst_n = 1'b1;

    run_op(2'b10, 16'd0, 5'd25, '0, '0, 0);
    run_op(2'b00, 16'd100, 5'd0, 16'h1234, '0, 0);
    run_op(2'b01, 16'd100, 5'd0, '0, '0, 0);
    run_op(2'b11, 16'd500, 5'd25, '0, mk_block(16'd1), 0);
    run_op(2'b10, 16'd505, 5'd10, '0, '0, 0);
    run_op(2'b10, 16'd2495, 5'd10, '0, '0, 0);
    run_op(2'b11, 16'd2498, 5'd4, '0, mk_block(16'hB000), 0);
    run_op(2'b10, 16'd2495, 5'd10, '0, '0, 0);
    run_op(2'b10, 16'd0, 5'd0, '0, '0, 0);
    run_op(2'b10, 16'd0, 5'd26, '0, '0, 0);
    run_op(2'b11, 16'd100, 5'd0, '0, mk_block(16'hDEAD), 0);
    run_op(2'b01, 16'd100, 5'd0, '0, '0, 0);
    run_op(2'b10, 16'd0, 5'd25, '0, '0, 3);

    // Abort a 25-word block write at cycle T+10: words 0..8 land, the rest keep old data.
    launch(2'b11, 16'd0, 5'd25, '0, mk_block(16'hA000));
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check_eq("abort_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_busy_off", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_dout", {16'd0, data_out}, 32'd0);
    check_eq("abort_bo", {31'd0, |block_out}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_no_done", {31'd0, done | busy}, 32'd0);
    end
    for (int i = 0; i < 9; i++) m_mem[i] = 16'hA000 + DW'(i);
    m_dout = '0;
    m_bo   = '0;
    run_op(2'b10, 16'd0, 5'd25, '0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
